// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Optional perf counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid #(
  parameter int DW          = 64,
  parameter bit BUBBLE_ZERO = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_bubble_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  logic [DW-1:0] main_reg;
  logic [DW-1:0] skid_reg;
  logic          main_vld_reg;
  logic          skid_vld_reg;
  logic          push;
  logic          pop;
  logic [DW-1:0] main_drop;
  state_t        state;

  // Handshake outputs come straight from flops: no out_ready -> in_ready path.
  assign in_ready  = ~skid_vld_reg;
  assign out_valid = main_vld_reg;
  assign out_data  = main_reg;

  assign push      = in_valid & ~skid_vld_reg & ~flush;
  assign pop       = main_vld_reg & out_ready;
  assign main_drop = BUBBLE_ZERO ? '0 : main_reg;
  assign state     = state_t'({main_vld_reg, skid_vld_reg});

  always_ff @(posedge clk) begin
    if (rst) begin
      main_reg     <= '0;
      skid_reg     <= '0;
      main_vld_reg <= 1'b0;
      skid_vld_reg <= 1'b0;
    end else if (flush) begin
      main_reg     <= main_drop;
      skid_reg     <= '0;
      main_vld_reg <= 1'b0;
      skid_vld_reg <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            main_reg     <= in_data;
            main_vld_reg <= 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_reg <= in_data;
          end else if (push) begin
            skid_reg     <= in_data;
            skid_vld_reg <= 1'b1;
          end else if (pop) begin
            main_reg     <= main_drop;
            main_vld_reg <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            main_reg     <= skid_reg;
            skid_reg     <= '0;
            skid_vld_reg <= 1'b0;
          end
        end
        default: begin
          // {0,1} is unreachable; fall back to a clean empty stage.
          main_reg     <= '0;
          skid_reg     <= '0;
          main_vld_reg <= 1'b0;
          skid_vld_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  // Event order: [0] stall, [1] bubble, [2] flush.
  logic [2:0]       perf_evt;
  logic [CNT_W-1:0] perf_cnt_reg [3];

  assign perf_evt = {flush, ~main_vld_reg, main_vld_reg & ~out_ready};

  for (genvar gi = 0; gi < 3; gi++) begin : g_perf
    always_ff @(posedge clk) begin
      if (rst) begin
        perf_cnt_reg[gi] <= '0;
      end else if (perf_evt[gi] && (perf_cnt_reg[gi] != {CNT_W{1'b1}})) begin
        perf_cnt_reg[gi] <= perf_cnt_reg[gi] + 1'b1;
      end
    end
  end

  assign perf_stall_cnt  = perf_cnt_reg[0];
  assign perf_bubble_cnt = perf_cnt_reg[1];
  assign perf_flush_cnt  = perf_cnt_reg[2];
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid (DW=32): directed vectors plus a
// randomized handshake section; a second instance runs with BUBBLE_ZERO=0.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic        h_in_ready, h_out_valid;
  logic [31:0] h_out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [3:0]  perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt;
  logic [3:0]  h_perf_stall_cnt, h_perf_bubble_cnt, h_perf_flush_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipe_stage_skid #(.DW(32), .BUBBLE_ZERO(1'b1), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_STAGE_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  pipe_stage_skid #(.DW(32), .BUBBLE_ZERO(1'b0), .CNT_W(4)) u_hold (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(h_in_ready), .in_data(in_data),
    .out_valid(h_out_valid), .out_ready(out_ready), .out_data(h_out_data)
`ifdef PIPE_STAGE_PERF_EN
    , .perf_stall_cnt(h_perf_stall_cnt), .perf_bubble_cnt(h_perf_bubble_cnt),
    .perf_flush_cnt(h_perf_flush_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every pop from the main instance is matched against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", out_data, 32'hxxxx_xxxx);
      end else begin
        check("beat_data", out_data, exp_q[0]);
        check("hold_beat_data", h_out_data, exp_q[0]);
        $display("beat %h", out_data);
        void'(exp_q.pop_front());
      end
    end
  end

  // Present one beat and hold it until accepted; enqueue on acceptance.
  task automatic push_beat(input logic [31:0] d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("push_timeout", 32'd0, 32'd1);
    else exp_q.push_back(d);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int start_cyc, occ;
    bit push_m, pop_m;
    logic [31:0] data_v;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cycles(2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 1: single beat, one-cycle latency, bubble zeroing vs hold
    @(posedge clk); #1;
    out_ready = 1'b1;
    push_beat(32'hA5A5_0001);
    @(negedge clk);
    check("t1_latency_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    check("t1_empty_valid", {31'd0, out_valid}, 32'd0);
    check("t1_bubble_zero", out_data, 32'd0);
    check("t1_hold_last", h_out_data, 32'hA5A5_0001);
    @(posedge clk); #1;

    // 2: 16 back-to-back beats, one per cycle
    start_cyc = cyc;
    for (int i = 1; i <= 16; i++) push_beat(i);
    check("t2_stream_cycles", cyc - start_cyc, 32'd16);
    cycles(3);

    // 3: backpressure fills the skid slot, then drains in order
    out_ready = 1'b0;
    push_beat(32'h11);
    push_beat(32'h12);
    in_valid = 1'b1; in_data = 32'h13;
    @(negedge clk);
    check("t3_in_ready_full", {31'd0, in_ready}, 32'd0);
    check("t3_main_data", out_data, 32'h11);
    cycles(2);
    @(negedge clk);
    check("t3_still_full", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    push_beat(32'h13);
    cycles(4);
    check("t3_drained", exp_q.size(), 32'd0);

    // 4: flush while FULL discards everything including the flush-cycle beat
    out_ready = 1'b0;
    push_beat(32'h21);
    push_beat(32'h22);
    in_valid = 1'b1; in_data = 32'h23; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t4_out_valid", {31'd0, out_valid}, 32'd0);
    check("t4_out_data", out_data, 32'd0);
    check("t4_in_ready", {31'd0, in_ready}, 32'd1);
    check("t4_hold_data", h_out_data, 32'h21);
    @(posedge clk); #1;
    out_ready = 1'b1;
    cycles(4);

    // 5: random handshakes against an occupancy model
    occ = 0; data_v = 32'h1000;
    in_valid = 1'b0; in_data = data_v;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      check("t5_in_ready", {31'd0, in_ready}, {31'd0, occ < 2});
      check("t5_out_valid", {31'd0, out_valid}, {31'd0, occ > 0});
      push_m = in_valid && (occ < 2);
      pop_m  = (occ > 0) && out_ready;
      if (push_m) exp_q.push_back(in_data);
      @(posedge clk); #1;
      occ = occ + int'(push_m) - int'(pop_m);
      if (push_m || !in_valid) begin
        in_valid = 1'($urandom % 2);
        data_v   = data_v + 1;
        in_data  = data_v;
      end
      out_ready = 1'($urandom % 2);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cycles(5);
    check("t5_drained", exp_q.size(), 32'd0);

`ifdef PIPE_STAGE_PERF_EN
    // 6: saturating perf counters, cleared only by reset
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_stall", {28'd0, perf_stall_cnt}, 32'd0);
    check("t6_rst_flush", {28'd0, perf_flush_cnt}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b1;
    cycles(3);
    flush = 1'b0;
    @(negedge clk);
    check("t6_flush_cnt", {28'd0, perf_flush_cnt}, 32'd3);
    @(posedge clk); #1;
    out_ready = 1'b0;
    push_beat(32'h55);
    cycles(20);
    @(negedge clk);
    check("t6_stall_sat", {28'd0, perf_stall_cnt}, 32'd15);
    check("t6_flush_kept", {28'd0, perf_flush_cnt}, 32'd3);
    @(posedge clk); #1;
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t6_clr_stall", {28'd0, perf_stall_cnt}, 32'd0);
    check("t6_clr_bubble", {28'd0, perf_bubble_cnt}, 32'd0);
    check("t6_clr_flush", {28'd0, perf_flush_cnt}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
